// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_pkg
// Description : Shared processor definitions used by the fetch unit. Holds the
//               fetch FSM state encoding and the sequential PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        ISSUE   = 2'd2,
        RESOLVE = 2'd3
    } fetch_state_e;

    // Byte distance between consecutive instruction words
    localparam logic [31:0] PC_INCREMENT = 32'd4;

endpackage : instruction_fetch_unit_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_next_pc_select.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_select
// Description : Combinational next-PC selection. Priority is jump, then taken
//               branch (BNE: Branch && !Zero), then sequential PC + 4. All
//               additions wrap modulo 2^32.
// Ports       : PC_i          - current program counter
//               Instruction_i - instruction being resolved
//               Branch_i      - branch instruction decoded
//               Jump_i        - jump instruction decoded
//               Zero_i        - ALU zero flag
//               NextPC_o      - selected next program counter
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_select
    import instruction_fetch_unit_pkg::*;
(
    input  logic [31:0] PC_i,
    input  logic [31:0] Instruction_i,
    input  logic        Branch_i,
    input  logic        Jump_i,
    input  logic        Zero_i,
    output logic [31:0] NextPC_o
);

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_offset_w;
    logic [31:0] branch_target_w;
    logic [31:0] jump_target_w;

    // Opcode bits are not part of any target calculation
    logic        unused_opcode_w;
    assign unused_opcode_w = &{1'b0, Instruction_i[31:26]};

    assign pc_plus4_w      = PC_i + PC_INCREMENT;
    // Sign-extended 16-bit word offset, converted to a byte offset
    assign branch_offset_w = {{14{Instruction_i[15]}}, Instruction_i[15:0], 2'b00};
    assign branch_target_w = pc_plus4_w + branch_offset_w;
    // Jump stays within the current 256 MB region of PC + 4
    assign jump_target_w   = {pc_plus4_w[31:28], Instruction_i[25:0], 2'b00};

    always_comb begin
        NextPC_o = pc_plus4_w;
        if (Jump_i) begin
            NextPC_o = jump_target_w;
        end else if (Branch_i && !Zero_i) begin
            NextPC_o = branch_target_w;
        end
    end

endmodule : next_pc_select
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Four-state fetch sequencer. Requests a word at the PC, holds
//               it for decode until accepted, then waits for the branch/jump
//               resolution of that instruction before loading the next PC.
// Config      : FETCH_COUNTER_EN - adds InstructionCount_o, a wrapping count
//               of instructions accepted by decode.
// Ports       : Clock_i                  - clock, rising edge
//               Reset_i                  - synchronous active-high reset
//               InstructionAddress_o     - fetch address (the PC)
//               InstructionRequest_o     - fetch request (state FETCH)
//               InstructionAcknowledge_i - memory data valid this cycle
//               InstructionData_i        - fetched word
//               Instruction_o            - held instruction for decode
//               InstructionValid_o       - Instruction_o valid (state ISSUE)
//               DecodeReady_i            - decode accepts Instruction_o
//               ResolveValid_i           - Branch/Jump/Zero valid
//               Branch_i, Jump_i, Zero_i - control and ALU resolution
//               InstructionCount_o       - accepted count (FETCH_COUNTER_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] ResetVector = 32'h0000_0000
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    output logic [31:0] InstructionAddress_o,
    output logic        InstructionRequest_o,
    input  logic        InstructionAcknowledge_i,
    input  logic [31:0] InstructionData_i,
    output logic [31:0] Instruction_o,
    output logic        InstructionValid_o,
    input  logic        DecodeReady_i,
    input  logic        ResolveValid_i,
    input  logic        Branch_i,
    input  logic        Jump_i,
    input  logic        Zero_i
`ifdef FETCH_COUNTER_EN
    ,
    output logic [31:0] InstructionCount_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc_w;
    logic         accept_w;

    next_pc_select u_next_pc_select (
        .PC_i          (pc_q),
        .Instruction_i (instr_q),
        .Branch_i      (Branch_i),
        .Jump_i        (Jump_i),
        .Zero_i        (Zero_i),
        .NextPC_o      (next_pc_w)
    );

    assign accept_w = (state_q == ISSUE) && DecodeReady_i;

    // Next-state logic. Acknowledge and resolve are only honoured in their
    // own states; elsewhere they fall through to the hold defaults.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (InstructionAcknowledge_i) begin
                    instr_d = InstructionData_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (DecodeReady_i) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (ResolveValid_i) begin
                    pc_d    = next_pc_w;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
            pc_q    <= ResetVector;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign InstructionAddress_o = pc_q;
    assign InstructionRequest_o = (state_q == FETCH);
    assign InstructionValid_o   = (state_q == ISSUE);
    assign Instruction_o        = instr_q;

`ifdef FETCH_COUNTER_EN
    logic [31:0] count_q;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            count_q <= 32'h0;
        end else if (accept_w) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign InstructionCount_o = count_q;
`else
    logic unused_accept_w;
    assign unused_accept_w = accept_w;
`endif

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench. Three fetch units with different reset
//               vectors share one stimulus stream and run in lockstep, so
//               wrap-around and high-region jump targets are visible without
//               steering a single PC across the address space.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        resolve;
    logic        branch;
    logic        jump;
    logic        zero;

    logic [31:0] addr_a, addr_b, addr_c;
    logic        req_a, req_b, req_c;
    logic [31:0] instr_a, instr_b, instr_c;
    logic        valid_a, valid_b, valid_c;
`ifdef FETCH_COUNTER_EN
    logic [31:0] cnt_a, cnt_b, cnt_c;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ResetVector(32'h0000_0000)) u_dut_a (
        .Clock_i(clk), .Reset_i(rst),
        .InstructionAddress_o(addr_a), .InstructionRequest_o(req_a),
        .InstructionAcknowledge_i(ack), .InstructionData_i(data),
        .Instruction_o(instr_a), .InstructionValid_o(valid_a),
        .DecodeReady_i(ready), .ResolveValid_i(resolve),
        .Branch_i(branch), .Jump_i(jump), .Zero_i(zero)
`ifdef FETCH_COUNTER_EN
        , .InstructionCount_o(cnt_a)
`endif
    );

    instruction_fetch_unit #(.ResetVector(32'h1000_0000)) u_dut_b (
        .Clock_i(clk), .Reset_i(rst),
        .InstructionAddress_o(addr_b), .InstructionRequest_o(req_b),
        .InstructionAcknowledge_i(ack), .InstructionData_i(data),
        .Instruction_o(instr_b), .InstructionValid_o(valid_b),
        .DecodeReady_i(ready), .ResolveValid_i(resolve),
        .Branch_i(branch), .Jump_i(jump), .Zero_i(zero)
`ifdef FETCH_COUNTER_EN
        , .InstructionCount_o(cnt_b)
`endif
    );

    instruction_fetch_unit #(.ResetVector(32'hFFFF_FFFC)) u_dut_c (
        .Clock_i(clk), .Reset_i(rst),
        .InstructionAddress_o(addr_c), .InstructionRequest_o(req_c),
        .InstructionAcknowledge_i(ack), .InstructionData_i(data),
        .Instruction_o(instr_c), .InstructionValid_o(valid_c),
        .DecodeReady_i(ready), .ResolveValid_i(resolve),
        .Branch_i(branch), .Jump_i(jump), .Zero_i(zero)
`ifdef FETCH_COUNTER_EN
        , .InstructionCount_o(cnt_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_req",   {31'd0, req_a},   32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_instr", instr_a,          32'h0);
        check("rst_addr_a", addr_a, 32'h0000_0000);
        check("rst_addr_b", addr_b, 32'h1000_0000);
        check("rst_addr_c", addr_c, 32'hFFFF_FFFC);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, then acknowledge
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_addr);
        int n = 0;
        while (!req_a && n < 20) begin
            step();
            n++;
        end
        check("fetch_req", {31'd0, req_a}, 32'd1);
        check("fetch_addr", addr_a, exp_addr);
        ack  = 1'b1;
        data = word;
        step();
        ack  = 1'b0;
        data = 32'h0;
        check("issue_valid", {31'd0, valid_a}, 32'd1);
        check("issue_instr", instr_a, word);
        check("issue_req",   {31'd0, req_a},   32'd0);
    endtask

    task automatic do_accept();
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("accept_valid", {31'd0, valid_a}, 32'd0);
    endtask

    task automatic do_resolve(input logic j, input logic b, input logic z);
        resolve = 1'b1;
        jump    = j;
        branch  = b;
        zero    = z;
        step();
        resolve = 1'b0;
        jump    = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;
        check("resolve_req", {31'd0, req_a}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; data = 32'h0; ready = 1'b0;
        resolve = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;

        // Reset release and first fetch latency
        do_reset();
        check("rel_idle_req", {31'd0, req_a}, 32'd0);
        step();
        check("rel_fetch_req", {31'd0, req_a}, 32'd1);
        check("rel_fetch_addr", addr_a, 32'h0);
        // Request held with stable address while memory is slow
        step();
        step();
        check("slow_req", {31'd0, req_a}, 32'd1);
        check("slow_addr", addr_a, 32'h0);
        do_fetch(32'h2008_0005, 32'h0);

        // Decode stall: stray ack and resolve must be ignored in ISSUE
        ack = 1'b1; data = 32'hDEAD_BEEF; resolve = 1'b1; jump = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_instr", instr_a, 32'h2008_0005);
            check("stall_valid", {31'd0, valid_a}, 32'd1);
            check("stall_req",   {31'd0, req_a},   32'd0);
        end
        ack = 1'b0; data = 32'h0; resolve = 1'b0; jump = 1'b0;
        do_accept();
        // Stray ack in RESOLVE must not recapture
        ack = 1'b1; data = 32'hCAFE_F00D;
        step();
        ack = 1'b0; data = 32'h0;
        check("resolve_hold_instr", instr_a, 32'h2008_0005);
        check("resolve_hold_req", {31'd0, req_a}, 32'd0);
        do_resolve(1'b0, 1'b0, 1'b0);
        check("seq_addr_a", addr_a, 32'h0000_0004);
        check("wrap_addr_c", addr_c, 32'h0000_0000);

        // Jump from 4 to 0x10
        do_fetch(32'h0800_0004, 32'h0000_0004);
        do_accept();
        do_resolve(1'b1, 1'b0, 1'b0);
        check("jump_addr", addr_a, 32'h0000_0010);

        // BNE taken backwards: 0x10 + 4 - 8 = 0x0C
        do_fetch(32'h1509_FFFE, 32'h0000_0010);
        do_accept();
        do_resolve(1'b0, 1'b1, 1'b0);
        check("bne_taken_addr", addr_a, 32'h0000_000C);

        // Back to 0x10, then BNE not taken (Zero = 1): 0x14
        do_fetch(32'h0800_0004, 32'h0000_000C);
        do_accept();
        do_resolve(1'b1, 1'b0, 1'b0);
        do_fetch(32'h1509_FFFE, 32'h0000_0010);
        do_accept();
        do_resolve(1'b0, 1'b1, 1'b1);
        check("bne_not_taken_addr", addr_a, 32'h0000_0014);

        // Jump beats branch; jump keeps upper nibble of PC + 4
        do_reset();
`ifdef FETCH_COUNTER_EN
        check("cnt_reset", cnt_a, 32'd0);
`endif
        do_fetch(32'h0800_0040, 32'h0000_0000);
        do_accept();
        do_resolve(1'b1, 1'b1, 1'b0);
        check("jump_pri_addr_b", addr_b, 32'h1000_0100);
        check("jump_pri_addr_a", addr_a, 32'h0000_0100);

        // Reset coincident with an acknowledge in FETCH
        do_fetch(32'h2008_0005, 32'h0000_0100);
        do_accept();
        do_resolve(1'b0, 1'b0, 1'b0);
        ack = 1'b1; data = 32'hDEAD_BEEF; rst = 1'b1;
        step();
        ack = 1'b0; data = 32'h0; rst = 1'b0;
        check("rstack_instr", instr_a, 32'h0);
        check("rstack_valid", {31'd0, valid_a}, 32'd0);
        check("rstack_req",   {31'd0, req_a},   32'd0);
        step();
        check("rstack_refetch_req",  {31'd0, req_a}, 32'd1);
        check("rstack_refetch_addr", addr_a, 32'h0);

        // Three sequential accepted instructions after reset
        do_fetch(32'h0000_0001, 32'h0000_0000);
        do_accept();
        do_resolve(1'b0, 1'b0, 1'b0);
        do_fetch(32'h0000_0002, 32'h0000_0004);
        do_accept();
        do_resolve(1'b0, 1'b0, 1'b0);
        do_fetch(32'h0000_0003, 32'h0000_0008);
        do_accept();
        do_resolve(1'b0, 1'b0, 1'b0);
        check("three_addr", addr_a, 32'h0000_000C);
`ifdef FETCH_COUNTER_EN
        check("cnt_three", cnt_a, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter ResetVector, default 32'h0000_0000, first instruction address after reset.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 InstructionAddress  output  32  word address of the instruction being fetched; always equals the PC.
REQ-005 InstructionRequest  output  1  fetch request to instruction memory.
REQ-006 InstructionAcknowledge  input  1  memory has placed the word on InstructionData this cycle.
REQ-007 InstructionData  input  32  fetched word, sampled only on an acknowledged request.
REQ-008 Instruction  output  32  held instruction word presented to decode and control.
REQ-009 InstructionValid  output  1  Instruction is valid.
REQ-010 DecodeReady  input  1  decode accepts Instruction when high with InstructionValid.
REQ-011 ResolveValid  input  1  Branch, Jump and Zero are valid for the accepted instruction.
REQ-012 Branch, Jump, Zero  input  1 each  control-unit decode and ALU result; Branch is not-equal (BNE) semantics.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, ISSUE and RESOLVE, with InstructionRequest = (state == FETCH) and InstructionValid = (state == ISSUE).
REQ-014 IDLE SHALL go to FETCH on the next cycle unconditionally.
REQ-015 In FETCH, InstructionRequest SHALL stay high, with InstructionAddress stable, until InstructionAcknowledge; on that cycle InstructionData is captured into Instruction and the state goes to ISSUE (ack-to-valid latency 1 cycle).
REQ-016 InstructionAcknowledge outside FETCH SHALL be ignored, with no capture and no state change.
REQ-017 In ISSUE, Instruction SHALL be held stable until InstructionValid && DecodeReady, after which the state goes to RESOLVE.
REQ-018 In RESOLVE, the unit SHALL wait for ResolveValid; on that cycle it loads the next PC and goes to FETCH, so the new InstructionAddress appears one cycle after ResolveValid.
REQ-019 The next PC SHALL be selected with this priority:
- Jump = 1: {PCplus4[31:28], Instruction[25:0], 2'b00}.
- Branch = 1 and Zero = 0: PCplus4 + (sign-extended Instruction[15:0] << 2).
- Otherwise: PCplus4.
REQ-020 PCplus4 = PC + 4 SHALL be computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000; branch addition also wraps silently.
REQ-021 Jump and Branch both high SHALL take the jump.
REQ-022 ResolveValid outside RESOLVE SHALL be ignored.

Reset
REQ-023 While Reset is high, the unit SHALL force:
- state = IDLE, PC = ResetVector, Instruction = 32'h0;
- InstructionRequest = 0, InstructionValid = 0.
REQ-024 Reset asserted mid-FETCH SHALL drop InstructionRequest on the next edge and discard any acknowledge arriving that cycle.
REQ-025 Reset asserted mid-ISSUE or mid-RESOLVE SHALL discard the held instruction and any pending redirect.

Configuration
REQ-026 With macro FETCH_COUNTER_EN defined, the module SHALL add output InstructionCount (32 bits):
- resets to 0;
- increments by 1 on each InstructionValid && DecodeReady cycle;
- wraps at 2^32.
REQ-027 Without FETCH_COUNTER_EN, the InstructionCount port and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-028 The state encoding typedef (IDLE=2'd0, FETCH=2'd1, ISSUE=2'd2, RESOLVE=2'd3) and the PC increment constant (4) SHALL live in the shared processor package.
REQ-029 Next-PC selection SHALL be one combinational sub-module named next_pc_select (inputs PC, Instruction, Branch, Jump, Zero; output NextPC); the FSM and registers stay in the top.

Verification
REQ-030 Reset release -> InstructionRequest = 1 with InstructionAddress = 32'h0 on the second cycle after release; ack with data 32'h2008_0005 -> Instruction = 32'h2008_0005 and InstructionValid = 1 on the next cycle.
REQ-031 DecodeReady held low 5 cycles in ISSUE -> Instruction and InstructionValid stable throughout; InstructionRequest stays 0.
REQ-032 PC = 32'h0000_0010, Instruction 32'h1509_FFFE, Branch = 1, Zero = 0 -> next InstructionAddress = 32'h0000_000C; same with Zero = 1 -> 32'h0000_0014.
REQ-033 PC = 32'h1000_0000, Instruction 32'h0800_0040, Jump = 1, Branch = 1 -> next InstructionAddress = 32'h1000_0100.
REQ-034 ResetVector = 32'hFFFF_FFFC, no branch or jump -> second fetch address = 32'h0000_0000.
REQ-035 Reset pulsed during FETCH, coincident with InstructionAcknowledge -> Instruction remains 32'h0, InstructionValid remains 0, and the next fetch is at ResetVector; with FETCH_COUNTER_EN, 3 accepted instructions -> InstructionCount = 3.
